// File: rtl/oai222_char_driver.sv
// Stimulus driver and response checker for an OAI222 cell under test: sweeps all
// 64 input vectors, samples QN after a settle window, counts mismatches and QN toggles.
module oai222_char_driver #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       start,
    input  logic       abort,
    input  logic       gray,
    input  logic       qn_obs,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       in4,
    output logic       in5,
    output logic       in6,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_cnt,
    output logic [5:0] first_err_vec,
    output logic       first_err_vld,
    output logic [5:0] qn_toggles
);

    localparam int unsigned VEC_W = 6;
    localparam int unsigned ERR_W = 7;
    localparam int unsigned TOG_W = 6;
    localparam int unsigned CNT_W = 4;
    localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(63);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gray_q, gray_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [VEC_W-1:0]   fev_q, fev_d;
    logic               fvld_q, fvld_d;
    logic [TOG_W-1:0]   tog_q, tog_d;
    logic               prev_q, prev_d;

    logic               exp_qn_c;
    logic               mismatch_c;
    logic               toggle_c;
    logic [VEC_W-1:0]   idx_inc_c;
    logic [ERR_W-1:0]   err_next_c;

    function automatic logic oai222(input logic [VEC_W-1:0] v);
        return !((v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]));
    endfunction

    function automatic logic [VEC_W-1:0] vec_of(input logic [VEC_W-1:0] i, input logic g);
        return g ? (i ^ (i >> 1)) : i;
    endfunction

    // Case-inequality so an undriven or unknown QN counts against the cell.
    assign exp_qn_c   = oai222(vec_q);
    assign mismatch_c = (qn_obs !== exp_qn_c);
    assign toggle_c   = (idx_q != '0) && (qn_obs != prev_q);
    assign idx_inc_c  = idx_q + VEC_W'(1);
    assign err_next_c = mismatch_c ? (err_q + ERR_W'(1)) : err_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            gray_q  <= 1'b0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= '0;
            fvld_q  <= 1'b0;
            tog_q   <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fvld_q  <= fvld_d;
            tog_q   <= tog_d;
            prev_q  <= prev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gray_d  = gray_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fvld_d  = fvld_q;
        tog_d   = tog_q;
        prev_d  = prev_q;

        if (abort) begin
            state_d = IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            fev_d   = '0;
            fvld_d  = 1'b0;
            tog_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = HOLD;
                        idx_d   = '0;
                        cnt_d   = SETTLE_LD;
                        gray_d  = gray;
                        vec_d   = vec_of('0, gray);
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        err_d   = '0;
                        fev_d   = '0;
                        fvld_d  = 1'b0;
                        tog_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        err_d  = err_next_c;
                        prev_d = qn_obs;
                        if (mismatch_c && !fvld_q) begin
                            fev_d  = vec_q;
                            fvld_d = 1'b1;
                        end
                        if (toggle_c) begin
                            tog_d = tog_q + TOG_W'(1);
                        end
                        if (idx_q != LAST_IDX) begin
                            idx_d = idx_inc_c;
                            vec_d = vec_of(idx_inc_c, gray_q);
                            cnt_d = SETTLE_LD;
                        end else begin
                            state_d = DONE;
                            vec_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_next_c == '0);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    vec_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    assign in1           = vec_q[0];
    assign in2           = vec_q[1];
    assign in3           = vec_q[2];
    assign in4           = vec_q[3];
    assign in5           = vec_q[4];
    assign in6           = vec_q[5];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_vec = fev_q;
    assign first_err_vld = fvld_q;
    assign qn_toggles    = tog_q;

endmodule

// File: tb/tb_oai222_char_driver.sv
// Scoreboarded bench for oai222_char_driver: a behavioural cell model closes the loop,
// a sweep-level reference model predicts the completion report of every full sweep.
module tb_oai222_char_driver;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned LAT    = 64 * (SETTLE + 1);

    typedef struct {
        int         err;
        logic [5:0] fvec;
        logic       fvld;
        int         tog;
        logic       pass;
        int         start_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstb, start, abort, gray, qn_obs;
    logic in1, in2, in3, in4, in5, in6;
    logic busy, done, pass, first_err_vld;
    logic [6:0] err_cnt;
    logic [5:0] first_err_vec, qn_toggles;
    logic [5:0] in_bus;

    int          mode = 0;
    logic [63:0] tbl  = '0;
    int          cyc  = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic        done_prev = 1'b0;

    oai222_char_driver #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .gray(gray),
        .qn_obs(qn_obs),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_err_vec(first_err_vec), .first_err_vld(first_err_vld),
        .qn_toggles(qn_toggles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_bus = {in6, in5, in4, in3, in2, in1};

    function automatic logic oai(input logic [5:0] v);
        return !((v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]));
    endfunction

    // Cell under test: 0 ideal, 1 stuck-1, 2 stuck-0, 3 QN wired to IN1, 4 ideal with faults.
    function automatic logic cell_qn(input int m, input logic [5:0] v, input logic [63:0] t);
        case (m)
            1: return 1'b1;
            2: return 1'b0;
            3: return v[0];
            4: return oai(v) ^ t[v];
            default: return oai(v);
        endcase
    endfunction

    always_comb qn_obs = cell_qn(mode, in_bus, tbl);

    // Expected end-of-sweep report from the list of 64 observed responses.
    function automatic exp_t model(input int m, input logic g, input logic [63:0] t);
        exp_t e;
        logic obs[64];
        logic [5:0] v;
        e.err = 0; e.fvec = '0; e.fvld = 1'b0; e.tog = 0; e.start_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            v = g ? 6'(i ^ (i >> 1)) : 6'(i);
            obs[i] = cell_qn(m, v, t);
            if (obs[i] != oai(v)) begin
                e.err++;
                if (!e.fvld) begin
                    e.fvld = 1'b1;
                    e.fvec = v;
                end
            end
        end
        for (int i = 1; i < 64; i++) if (obs[i] != obs[i-1]) e.tog++;
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in"},    32'(in_bus),        0);
        chk({tag, "_busy"},  32'(busy),          0);
        chk({tag, "_done"},  32'(done),          0);
        chk({tag, "_pass"},  32'(pass),          0);
        chk({tag, "_err"},   32'(err_cnt),       0);
        chk({tag, "_fvec"},  32'(first_err_vec), 0);
        chk({tag, "_fvld"},  32'(first_err_vld), 0);
        chk({tag, "_tog"},   32'(qn_toggles),    0);
    endtask

    // Monitor: each rising DONE retires the oldest expected sweep report.
    always @(negedge clk) begin
        if (!rstb) begin
            done_prev <= 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("err_cnt",       32'(err_cnt),       32'(mon_e.err));
                    chk("first_err_vec", 32'(first_err_vec), 32'(mon_e.fvec));
                    chk("first_err_vld", 32'(first_err_vld), 32'(mon_e.fvld));
                    chk("qn_toggles",    32'(qn_toggles),    32'(mon_e.tog));
                    chk("pass",          32'(pass),          32'(mon_e.pass));
                    chk("busy_at_done",  32'(busy),          0);
                    chk("in_at_done",    32'(in_bus),        0);
                    chk("done_latency",  32'(cyc - mon_e.start_cyc), 32'(LAT + 1));
                end
            end
            done_prev <= done;
        end
    end

    task automatic wait_done();
        int c = 0;
        while (!done && c < int'(LAT) + 20) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            chk("sweep_timeout", 32'(done), 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    // One full sweep; optional noise pulses START and flips GRAY while busy.
    task automatic do_sweep(input int m, input logic g, input logic [63:0] t, input bit noise);
        exp_t e;
        @(negedge clk);
        mode  = m;
        tbl   = t;
        gray  = g;
        start = 1'b1;
        e = model(m, g, t);
        e.start_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (noise) begin
            repeat (150) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1));
                gray  = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstb = 1'b0; start = 1'b0; abort = 1'b0; gray = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rstb = 1'b1;

        do_sweep(0, 1'b0, '0, 1'b0);
        do_sweep(1, 1'b0, '0, 1'b0);
        do_sweep(2, 1'b0, '0, 1'b0);
        do_sweep(2, 1'b1, '0, 1'b0);
        do_sweep(3, 1'b0, '0, 1'b0);
        do_sweep(3, 1'b1, '0, 1'b1);
        for (int n = 0; n < 8; n++)
            do_sweep(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                     {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // Abort with START in the same cycle while vector 10 is held.
        @(negedge clk);
        mode = 2; gray = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 1);
        chk("vec_before_abort",  32'(in_bus), 10);
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        chk_idle("abort");
        repeat (5) @(negedge clk);
        chk_idle("abort_hold");
        do_sweep(0, 1'b1, '0, 1'b0);

        // Asynchronous reset mid-sweep, then stay idle after release.
        @(negedge clk);
        mode = 2; gray = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 1);
        #2 rstb = 1'b0;
        #1 chk_idle("async_rst");
        @(negedge clk);
        #2 rstb = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle("post_rst");
        do_sweep(4, 1'b1, {$urandom, $urandom}, 1'b1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
